// File: rtl/alu_seq.sv
// Registered, handshaked ALU with a 4-bit opcode space, carry/negative flags
// and an optional multi-cycle shift-add multiplier (opcode 4'hC).
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             is_zero,
    output logic             carry,
    output logic             negative,
    output logic             busy
);

    localparam int   SH_W   = $clog2(WIDTH);
    localparam int   CNT_W  = $clog2(WIDTH + 1);
    localparam logic MUL_ON = (MUL_EN != 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [WIDTH-1:0]       alu_out_r;
    logic                   is_zero_r, carry_r, negative_r, out_valid_r;
    logic [2*WIDTH-1:0]     mcand_r, prod_r;
    logic [WIDTH-1:0]       mplier_r;
    logic [CNT_W-1:0]       cnt_r;

    logic                   in_ready_s, accept_s, mul_op_s;
    logic [SH_W-1:0]        sh_s;
    logic [WIDTH:0]         sum_s, shl_s, shr_s;
    logic [WIDTH-1:0]       res_s;
    logic                   cy_s;
    logic [2*WIDTH-1:0]     prod_add_s;

    assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign mul_op_s   = MUL_ON && (opcode == 4'hC);
    assign sh_s       = in_b[SH_W-1:0];

    // shl_s[WIDTH] is the last bit shifted out on the left; shr_s[0] on the right
    assign sum_s      = {1'b0, in_a} + {1'b0, in_b};
    assign shl_s      = {1'b0, in_a} << sh_s;
    assign shr_s      = {in_a, 1'b0} >> sh_s;
    assign prod_add_s = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    // Single-cycle result and carry selection
    always_comb begin
        res_s = in_a;
        cy_s  = 1'b0;
        case (opcode)
            4'h2: begin res_s = sum_s[WIDTH-1:0]; cy_s = sum_s[WIDTH]; end
            4'h3: res_s = in_a & in_b;
            4'h4: res_s = in_a ^ in_b;
            4'h5: res_s = in_b;
            4'h8: begin res_s = in_a - in_b; cy_s = (in_a >= in_b); end
            4'h9: res_s = in_a | in_b;
            4'hA: begin res_s = shl_s[WIDTH-1:0]; cy_s = shl_s[WIDTH]; end
            4'hB: begin res_s = shr_s[WIDTH:1]; cy_s = shr_s[0]; end
            default: begin res_s = in_a; cy_s = 1'b0; end
        endcase
    end

    // Multiplier FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Multiplier FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && mul_op_s) state_s = ST_MUL;
                else                      state_s = ST_IDLE;
            end
            ST_MUL: begin
                if (cnt_r == CNT_W'(1)) state_s = ST_IDLE;
                else                    state_s = ST_MUL;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Result/flag registers and shift-add multiplier datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_r   <= {WIDTH{1'b0}};
            is_zero_r   <= 1'b0;
            carry_r     <= 1'b0;
            negative_r  <= 1'b0;
            out_valid_r <= 1'b0;
            mcand_r     <= {(2*WIDTH){1'b0}};
            prod_r      <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else if (accept_s && mul_op_s) begin
            mcand_r     <= {{WIDTH{1'b0}}, in_a};
            mplier_r    <= in_b;
            prod_r      <= {(2*WIDTH){1'b0}};
            cnt_r       <= CNT_W'(WIDTH);
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            alu_out_r   <= res_s;
            is_zero_r   <= (res_s == {WIDTH{1'b0}});
            carry_r     <= cy_s;
            negative_r  <= res_s[WIDTH-1];
            out_valid_r <= 1'b1;
        end else if (state_r == ST_MUL) begin
            prod_r   <= prod_add_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                alu_out_r   <= prod_add_s[WIDTH-1:0];
                is_zero_r   <= (prod_add_s[WIDTH-1:0] == {WIDTH{1'b0}});
                carry_r     <= |prod_add_s[2*WIDTH-1:WIDTH];
                negative_r  <= prod_add_s[WIDTH-1];
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign alu_out   = alu_out_r;
    assign is_zero   = is_zero_r;
    assign carry     = carry_r;
    assign negative  = negative_r;
    assign busy      = MUL_ON && (state_r == ST_MUL);

endmodule
